uart_rx: RTL and testbench

//  Receive half of the UART link. Deserialises frames from the uart_Tx line:

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: one clk per bit, frame = start, DATA_BITS data (LSB first), even parity, stop.
// Define UART_RX_SYNC_EN to insert a 2-flop synchroniser on RxD (adds 2 cycles of latency).
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic       ack,
  output logic [7:0] RxData,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        rxd;

`ifdef UART_RX_SYNC_EN
  // Synchroniser resets to the idle line level so reset never fakes a start bit
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RxD};
    end
  end

  assign rxd = sync_q[1];
`else
  assign rxd = RxD;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    // Consumer handshake first; a commit in the same cycle overrides valid below
    if (ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxd) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        shift_d[cnt_q] = rxd;
        if (cnt_q == LAST_BIT) begin
          state_d = S_PARITY;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_PARITY: begin
        par_d   = rxd;
        state_d = S_STOP;
      end
      S_STOP: begin
        data_d  = shift_q;
        valid_d = 1'b1;
        perr_d  = (^shift_q) != par_q;
        ferr_d  = ~rxd;
        if (valid_q && !ack) begin
          ovr_d = 1'b1;
        end
        state_d = rxd ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (rxd) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign RxData     = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: pre-built line/ack/reset schedule, frame-level reference model,
// per-cycle comparison of every output plus literal pins on the directed scenarios.
module tb_uart_rx;
  localparam int N = 2400;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic       ack;
  logic [7:0] RxData;
  logic       valid, parity_err, frame_err, overrun, busy;

  uart_rx #(.DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .ack(ack),
    .RxData(RxData), .valid(valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // stimulus schedule, index = cycle number
  bit         rxd_a [N];
  bit         ack_a [N];
  bit         rstn_a[N];
  // line as the receiver core sees it, frame commits, expected outputs
  bit         eff   [N];
  bit         cm    [N];
  logic [7:0] cm_d  [N];
  bit         cm_pe [N];
  bit         cm_fe [N];
  bit         busy_e[N];
  logic [7:0] d_e   [N];
  bit         v_e   [N];
  bit         pe_e  [N];
  bit         fe_e  [N];
  bit         ov_e  [N];

  typedef struct {
    int    cyc;
    int    fld;
    int    val;
    string name;
  } pin_t;
  pin_t pins[$];

  int errors = 0;
  int checks = 0;

  task automatic put_frame(input int t, input logic [7:0] b, input bit badpar, input bit stop);
    rxd_a[t] = 1'b0;
    for (int i = 0; i < 8; i++) rxd_a[t+1+i] = b[i];
    rxd_a[t+9]  = (^b) ^ badpar;
    rxd_a[t+10] = stop;
  endtask

  task automatic pin(input int cyc, input int fld, input int val, input string name);
    pin_t e;
    e.cyc = cyc; e.fld = fld; e.val = val; e.name = name;
    pins.push_back(e);
  endtask

  function automatic int dut_field(input int f);
    case (f)
      0: return int'(RxData);
      1: return int'(valid);
      2: return int'(parity_err);
      3: return int'(frame_err);
      4: return int'(overrun);
      default: return int'(busy);
    endcase
  endfunction

  task automatic check(input string name, input int cyc, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic build_model();
    int i, t, j;
    bit ab;
    logic [7:0] d;
    bit v, pe, fe, ov, acc;
    // line after the optional synchroniser; reset forces it to idle
    for (int k = 0; k < N; k++) begin
      if (k < LAT) eff[k] = 1'b1;
      else begin
        eff[k] = rxd_a[k-LAT];
        for (int m = 1; m <= LAT; m++)
          if (!rstn_a[k-m]) eff[k] = 1'b1;
      end
    end
    // frame-level scan of the line
    i = 0;
    while (i < N) begin
      if (!rstn_a[i] || eff[i]) begin
        i++;
        continue;
      end
      t = i;
      ab = 1'b0;
      for (j = t + 1; j <= t + 10; j++) begin
        if (j >= N) begin ab = 1'b1; break; end
        busy_e[j] = 1'b1;
        if (!rstn_a[j]) begin ab = 1'b1; break; end
      end
      if (ab) begin
        i = j + 1;
        continue;
      end
      cm[t+10] = 1'b1;
      for (int b = 0; b < 8; b++) cm_d[t+10][b] = eff[t+1+b];
      cm_pe[t+10] = (^cm_d[t+10]) != eff[t+9];
      cm_fe[t+10] = !eff[t+10];
      if (eff[t+10]) i = t + 11;
      else begin
        j = t + 11;
        while (j < N && !eff[j] && rstn_a[j]) begin
          busy_e[j] = 1'b1;
          j++;
        end
        if (j < N) busy_e[j] = 1'b1;
        i = j + 1;
      end
    end
    // output holding register and handshake, edge by edge
    d = 8'h00; v = 0; pe = 0; fe = 0; ov = 0;
    for (int k = 1; k < N; k++) begin
      if (!rstn_a[k-1]) begin
        d = 8'h00; v = 0; pe = 0; fe = 0; ov = 0;
      end else begin
        acc = ack_a[k-1] && v;
        if (cm[k-1]) begin
          d  = cm_d[k-1];
          pe = cm_pe[k-1];
          fe = cm_fe[k-1];
          ov = acc ? 1'b0 : (v ? 1'b1 : ov);
          v  = 1'b1;
        end else if (acc) begin
          v  = 1'b0;
          ov = 1'b0;
        end
      end
      d_e[k] = d; v_e[k] = v; pe_e[k] = pe; fe_e[k] = fe; ov_e[k] = ov;
    end
  endtask

  initial begin
    int t1, t2, t3, t4, t5, t6, p;
    logic [7:0] b;
    bit bp, st;
    reset = 1'b0;
    RxD   = 1'b1;
    ack   = 1'b0;
    for (int k = 0; k < N; k++) begin
      rxd_a[k] = 1'b1; ack_a[k] = 1'b0; rstn_a[k] = 1'b1;
    end
    for (int k = 0; k < 3; k++) rstn_a[k] = 1'b0;
    pin(1, 1, 0, "rst_valid");
    pin(1, 0, 0, "rst_data");
    pin(1, 5, 0, "rst_busy");
    pin(1, 4, 0, "rst_overrun");

    // good A5 frame, latency and ack
    t1 = 6;
    put_frame(t1, 8'hA5, 1'b0, 1'b1);
    pin(t1+10+LAT, 1, 0, "t1_valid_early");
    pin(t1+10+LAT, 5, 1, "t1_busy_stop");
    pin(t1+11+LAT, 1, 1, "t1_valid");
    pin(t1+11+LAT, 0, 8'hA5, "t1_data");
    pin(t1+11+LAT, 2, 0, "t1_perr");
    pin(t1+11+LAT, 3, 0, "t1_ferr");
    pin(t1+11+LAT, 4, 0, "t1_ovr");
    pin(t1+11+LAT, 5, 0, "t1_busy_done");
    ack_a[t1+12+LAT] = 1'b1;
    pin(t1+13+LAT, 1, 0, "t1_valid_acked");

    // wrong parity on 01
    t2 = t1 + 16;
    put_frame(t2, 8'h01, 1'b1, 1'b1);
    pin(t2+11+LAT, 0, 8'h01, "t2_data");
    pin(t2+11+LAT, 1, 1, "t2_valid");
    pin(t2+11+LAT, 2, 1, "t2_perr");
    ack_a[t2+12+LAT] = 1'b1;

    // framing error followed by a 5-cycle break
    t3 = t2 + 16;
    put_frame(t3, 8'h3C, 1'b0, 1'b0);
    for (int k = 11; k < 16; k++) rxd_a[t3+k] = 1'b0;
    pin(t3+11+LAT, 3, 1, "t3_ferr");
    pin(t3+11+LAT, 0, 8'h3C, "t3_data");
    pin(t3+16+LAT, 5, 1, "t3_busy_break");
    pin(t3+17+LAT, 5, 0, "t3_busy_idle");
    pin(t3+28+LAT, 0, 8'h3C, "t3_no_spurious");
    ack_a[t3+29+LAT] = 1'b1;
    pin(t3+30+LAT, 1, 0, "t3_valid_acked");

    // back-to-back frames, no ack -> overrun
    t4 = t3 + 34;
    put_frame(t4, 8'h11, 1'b0, 1'b1);
    put_frame(t4+12, 8'h22, 1'b0, 1'b1);
    pin(t4+11+LAT, 4, 0, "t4_ovr_first");
    pin(t4+23+LAT, 0, 8'h22, "t4_data");
    pin(t4+23+LAT, 4, 1, "t4_ovr");
    pin(t4+23+LAT, 1, 1, "t4_valid");
    ack_a[t4+24+LAT] = 1'b1;
    pin(t4+25+LAT, 1, 0, "t4_valid_acked");
    pin(t4+25+LAT, 4, 0, "t4_ovr_cleared");

    // ack coincides with the second commit
    t5 = t4 + 28;
    put_frame(t5, 8'h33, 1'b0, 1'b1);
    put_frame(t5+12, 8'h44, 1'b0, 1'b1);
    ack_a[t5+22+LAT] = 1'b1;
    pin(t5+23+LAT, 1, 1, "t5_valid");
    pin(t5+23+LAT, 0, 8'h44, "t5_data");
    pin(t5+23+LAT, 4, 0, "t5_ovr");

    // reset mid-frame discards the held 44 and the partial frame
    t6 = t5 + 28;
    put_frame(t6, 8'h55, 1'b0, 1'b1);
    rstn_a[t6+5] = 1'b0;
    rxd_a[t6+6] = 1'b1;
    rxd_a[t6+7] = 1'b1;
    pin(t6+5, 1, 1, "t6_valid_before");
    pin(t6+5, 5, 1, "t6_busy_before");
    pin(t6+6, 1, 0, "t6_valid_rst");
    pin(t6+6, 0, 0, "t6_data_rst");
    pin(t6+6, 5, 0, "t6_busy_rst");
    put_frame(t6+8, 8'hFF, 1'b0, 1'b1);
    pin(t6+19+LAT, 0, 8'hFF, "t6_ff_data");
    pin(t6+19+LAT, 1, 1, "t6_ff_valid");
    pin(t6+19+LAT, 2, 0, "t6_ff_perr");
    pin(t6+19+LAT, 3, 0, "t6_ff_ferr");
    ack_a[t6+21+LAT] = 1'b1;

    // randomized traffic, errors, breaks, resets and acks
    p = t6 + 30;
    for (int k = p; k < N; k++) ack_a[k] = ($urandom_range(0, 4) == 0);
    while (p < N - 40) begin
      p += $urandom_range(1, 4);
      b  = 8'($urandom);
      bp = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 7) != 0);
      put_frame(p, b, bp, st);
      p += 11;
      if (!st) begin
        int n;
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) rxd_a[p+i] = 1'b0;
        p += n;
      end
      if ($urandom_range(0, 29) == 0) rstn_a[p - $urandom_range(1, 12)] = 1'b0;
    end

    build_model();

    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      RxD   = rxd_a[k];
      ack   = ack_a[k];
      reset = rstn_a[k];
      @(negedge clk);
      if (k >= 1) begin
        check("RxData",     k, int'(RxData),     int'(d_e[k]));
        check("valid",      k, int'(valid),      int'(v_e[k]));
        check("parity_err", k, int'(parity_err), int'(pe_e[k]));
        check("frame_err",  k, int'(frame_err),  int'(fe_e[k]));
        check("overrun",    k, int'(overrun),    int'(ov_e[k]));
        check("busy",       k, int'(busy),       int'(busy_e[k]));
        foreach (pins[i])
          if (pins[i].cyc == k) check(pins[i].name, k, dut_field(pins[i].fld), pins[i].val);
      end
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
